// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// The state enum is exported so the top can expose it on a debug port.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-step operation still needs a one-bit counter register.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_slice.sv
// Combinational ripple of DIGIT full-adder bits for one digit step.
// cin_msb is the carry into the top bit; together with co it yields signed overflow.
module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cin_msb
);

    always_comb begin
        logic [DIGIT:0] c;
        c    = '0;
        c[0] = ci;
        s    = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co      = c[DIGIT];
        cin_msb = c[DIGIT-1];
    end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through one adder_slice,
// with a registered carry and a valid/ready handshake on both sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds data while valid is high, and in_ready/out_valid
    // depend only on state, never combinationally on in_valid/out_ready.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output state_e           dbg_state
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    if ((DIGIT < 1) || (WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [DIGIT-1:0]   x_dig, y_dig, s_dig;
    logic               slice_co, slice_cin_msb;
    logic               last_step;

    assign x_dig     = a_q[cnt_q*DIGIT +: DIGIT];
    assign y_dig     = b_q[cnt_q*DIGIT +: DIGIT];
    assign last_step = (cnt_q == LAST_CNT);

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x       (x_dig),
        .y       (y_dig),
        .ci      (carry_q),
        .s       (s_dig),
        .co      (slice_co),
        .cin_msb (slice_cin_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = BUSY;
            BUSY:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + ~borrow_in, so B is inverted once at accept time.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    sub_d   = sub;
                    carry_d = c_in ^ sub;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = s_dig;
                carry_d = slice_co;
                if (last_step) begin
                    cnt_d   = '0;
                    c_out_d = slice_co ^ sub_q;
                    ovf_d   = slice_cin_msb ^ slice_co;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT=1,4,16, WIDTH=16) share the
// operand and handshake inputs and are checked against an arithmetic reference.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 16;
    localparam int NI = 3;
    int dig_of[NI]  = '{1, 4, 16};
    int ndig_of[NI] = '{16, 4, 1};

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic [W-1:0]  a, b;
    logic          c_in, sub;

    logic [NI-1:0] in_ready_w;
    logic [NI-1:0] out_valid_w;
    logic [NI-1:0] c_out_w;
    logic [NI-1:0] ovf_w;
    logic [W-1:0]  sum_w [NI];
    state_e        dbg_w [NI];

    int n_checks;
    int n_errors;

    // Expected {ovf, c_out, sum} of the operation in flight.
    logic [W+1:0] exp_q[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_adder #(
            .WIDTH (W),
            .DIGIT ((g == 0) ? 1 : ((g == 1) ? 4 : 16))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a         (a),
            .b         (b),
            .c_in      (c_in),
            .sub       (sub),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .sum       (sum_w[g]),
            .c_out     (c_out_w[g]),
            .ovf       (ovf_w[g]),
            .dbg_state (dbg_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic rc, input logic rs);
        int ua, ub, sa, sb, ru, rsg;
        logic co, ov;
        ua = int'(ra);
        ub = int'(rb);
        sa = int'($signed(ra));
        sb = int'($signed(rb));
        if (!rs) begin
            ru  = ua + ub + int'(rc);
            rsg = sa + sb + int'(rc);
            co  = (ru > 65535);
        end else begin
            ru  = ua - ub - int'(rc);
            rsg = sa - sb - int'(rc);
            co  = (ru < 0);
        end
        ov = (rsg > 32767) || (rsg < -32768);
        return {ov, co, W'(ru)};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (in_ready_w != '1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready_w != '1) check_eq("idle_timeout", 32'(in_ready_w), 32'(3'b111));
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
        logic [NI-1:0] done;
        logic [W+1:0]  exp;
        wait_idle();
        exp_q.push_back(ref_model(ta, tb_v, tc, ts));
        a         = ta;
        b         = tb_v;
        c_in      = tc;
        sub       = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        // Scramble operands after the accept edge; results must not change.
        in_valid = 1'b0;
        a        = rand_operand();
        b        = rand_operand();
        c_in     = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        exp      = exp_q[0];
        done     = '0;
        for (int n = 1; n <= 40 && done != '1; n++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < NI; g++) begin
                if (!done[g] && out_valid_w[g]) begin
                    done[g] = 1'b1;
                    check_eq($sformatf("lat_d%0d", dig_of[g]), 32'(n), 32'(ndig_of[g]));
                    check_eq($sformatf("sum_d%0d %h%s%h", dig_of[g], ta, ts ? "-" : "+", tb_v),
                             32'(sum_w[g]), 32'(exp[W-1:0]));
                    check_eq($sformatf("c_out_d%0d", dig_of[g]), 32'(c_out_w[g]), 32'(exp[W]));
                    check_eq($sformatf("ovf_d%0d", dig_of[g]), 32'(ovf_w[g]), 32'(exp[W+1]));
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            if (!done[g]) check_eq($sformatf("done_timeout_d%0d", dig_of[g]), 32'(0), 32'(1));
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        logic [W+1:0] exp;
        int           n;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("rst_state_d%0d", dig_of[g]), 32'(dbg_w[g]), 32'(IDLE));
            check_eq($sformatf("rst_in_ready_d%0d", dig_of[g]), 32'(in_ready_w[g]), 32'(1));
            check_eq($sformatf("rst_out_valid_d%0d", dig_of[g]), 32'(out_valid_w[g]), 32'(0));
            check_eq($sformatf("rst_sum_d%0d", dig_of[g]), 32'(sum_w[g]), 32'(0));
            check_eq($sformatf("rst_flags_d%0d", dig_of[g]), 32'({c_out_w[g], ovf_w[g]}), 32'(0));
        end

        // Directed arithmetic cases
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        check_eq("const_ref_5555", 32'(ref_model(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'({2'b00, 16'h5555}));

        // Back-pressure in DONE with in_valid pulses while busy
        wait_idle();
        exp       = ref_model(16'h1111, 16'h2222, 1'b0, 1'b0);
        a         = 16'h1111;
        b         = 16'h2222;
        c_in      = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        while (!out_valid_w[1] && n < 20) begin
            in_valid = ~in_valid;
            a        = rand_operand();
            check_eq("hs_busy_in_ready", 32'(in_ready_w[1]), 32'(0));
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("hs_reach_done", 32'(out_valid_w[1]), 32'(1));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'(i % 2);
            b        = rand_operand();
            @(posedge clk);
            #1;
            check_eq("hs_hold_valid", 32'(out_valid_w[1]), 32'(1));
            check_eq("hs_hold_sum", 32'(sum_w[1]), 32'(exp[W-1:0]));
            check_eq("hs_hold_in_ready", 32'(in_ready_w[1]), 32'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hs_release_in_ready", 32'(in_ready_w[1]), 32'(1));
        check_eq("hs_release_out_valid", 32'(out_valid_w[1]), 32'(0));
        @(posedge clk);
        #1;
        check_eq("hs_no_stray_accept", 32'(dbg_w[1]), 32'(IDLE));

        // Reset in the middle of an operation (DIGIT=4 instance at cnt==2)
        wait_idle();
        a        = 16'h0F0F;
        b        = 16'h0101;
        c_in     = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_busy_before_rst", 32'(dbg_w[1]), 32'(BUSY));
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check_eq($sformatf("arst_state_d%0d", dig_of[g]), 32'(dbg_w[g]), 32'(IDLE));
            check_eq($sformatf("arst_out_valid_d%0d", dig_of[g]), 32'(out_valid_w[g]), 32'(0));
            check_eq($sformatf("arst_sum_d%0d", dig_of[g]), 32'(sum_w[g]), 32'(0));
            check_eq($sformatf("arst_in_ready_d%0d", dig_of[g]), 32'(in_ready_w[g]), 32'(1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);

        // Random sweep on all three digit sizes at once
        for (int i = 0; i < 1000; i++) begin
            run_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
